// File: rtl/mux_pkg.sv
// Shared selector package: data/select widths and the 4:1 select function
// reused by every small steering leaf in the selector family.
package mux_pkg;

   localparam int N_IN  = 4;
   localparam int SEL_W = 2;

   // Pick d[sel]. An unknown select code falls to the default branch and
   // yields 0, so the output is never X from the select alone.
   function automatic logic sel4(input logic [3:0] d, input logic [1:0] sel);
      logic r;
      r = 1'b0;
      case (sel)
         2'b00:   r = d[0];
         2'b01:   r = d[1];
         2'b10:   r = d[2];
         2'b11:   r = d[3];
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mux4to1_func_select.sv
// 4:1 single-bit selector: f = I[s] combinationally, plus a registered copy
// f_q (captured when en=1) and a one-cycle f_chg pulse when a capture
// changed f_q. Port order keeps (I, s, f) first so a positional three-port
// instantiation works for purely combinational users.
module mux4to1_func_select
   import mux_pkg::sel4;
#(
   parameter int   N_IN    = mux_pkg::N_IN,
   parameter int   SEL_W   = mux_pkg::SEL_W,
   parameter logic RST_VAL = 1'b0
) (
   input  logic [N_IN-1:0]  I,
   input  logic [SEL_W-1:0] s,
   output logic             f,
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic             f_q,
   output logic             f_chg
);

   // Combinational select; reset and clock have no influence on f.
   always_comb begin
      f = sel4(I, s);
   end

   // Capture f when enabled and flag a change against the previous capture.
   // NOTE: non-blocking assignments so f_chg compares against the old f_q,
   // not the value being written on this same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_q   <= RST_VAL;
         f_chg <= 1'b0;
      end else if (en) begin
         f_q   <= f;
         f_chg <= (f != f_q);
      end else begin
         f_chg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux4to1_func_select.sv
// Self-checking bench for mux4to1_func_select: exhaustive combinational
// sweep, reset behaviour, directed register-path cases and a randomized run
// against a behavioural model of the selected bit and its captured copy.
module tb_mux4to1_func_select;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [3:0] I = 4'd0;
   logic [1:0] s = 2'd0;
   logic       f, f_q, f_chg;

   int checks = 0;
   int errors = 0;

   // model state: last captured bit and change flag
   logic m_q   = 1'b0;
   logic m_chg = 1'b0;

   always #5 clk = ~clk;

   mux4to1_func_select dut (
      .I     (I),
      .s     (s),
      .f     (f),
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .f_q   (f_q),
      .f_chg (f_chg)
   );

   // selected bit as plain arithmetic: shift the data word right by the code
   function automatic logic ref_f(input logic [3:0] d, input logic [1:0] sel);
      int v;
      v = (int'(d) >> int'(sel)) % 2;
      return (v != 0);
   endfunction

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // inputs are driven on the falling edge, so the values present now are
   // the ones the rising edge sampled; advance the model and compare
   task automatic tick(input string tag);
      logic exp_f;
      @(posedge clk);
      #1;
      exp_f = ref_f(I, s);
      if (en) begin
         m_chg = (exp_f != m_q);
         m_q   = exp_f;
      end else begin
         m_chg = 1'b0;
      end
      check({tag, "_f"},     f,     exp_f);
      check({tag, "_f_q"},   f_q,   m_q);
      check({tag, "_f_chg"}, f_chg, m_chg);
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      // exhaustive sweep held in reset: f follows I[s], registers stay cleared
      for (int si = 0; si < 4; si++) begin
         for (int ii = 0; ii < 16; ii++) begin
            s = si[1:0];
            I = ii[3:0];
            #1;
            check("sweep_f", f, ref_f(I, s));
            if (ii == 0) begin
               check("sweep_rst_f_q", f_q, 1'b0);
               check("sweep_rst_f_chg", f_chg, 1'b0);
            end
            #9;
         end
      end

      // spot values
      s = 2'b10; I = 4'b0100; #1; check("spot_s2", f, 1'b1);
      s = 2'b11; I = 4'b0111; #1; check("spot_s3", f, 1'b0);
      s = 2'b00; I = 4'b0001; #1; check("spot_s0", f, 1'b1);

      // reset held across clock edges with random inputs
      en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         I = 4'($urandom);
         s = 2'($urandom);
         #3;
         check("rst_f", f, ref_f(I, s));
         check("rst_f_q", f_q, 1'b0);
         check("rst_f_chg", f_chg, 1'b0);
      end

      // release with en=0: f_q must hold the reset value
      @(negedge clk);
      en = 1'b0;
      I = 4'b1111;
      s = 2'b00;
      rst_n = 1'b1;
      #1;
      check("release_f_q", f_q, 1'b0);
      @(negedge clk);
      m_q = 1'b0;
      m_chg = 1'b0;
      tick("release_hold");
      tick("release_hold");

      // register path: capture 1, pulse, then pulse drops
      en = 1'b1;
      s = 2'b01;
      I = 4'b0010;
      #1;
      check("reg_f", f, 1'b1);
      tick("reg_cap");
      check("reg_cap_q_is_1", f_q, 1'b1);
      check("reg_cap_chg_is_1", f_chg, 1'b1);
      tick("reg_steady");
      check("reg_steady_chg_is_0", f_chg, 1'b0);

      // enable low: toggle the selected bit, f_q holds, no pulses
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         I = I ^ (4'd1 << s);
         tick("hold");
         check("hold_q_is_1", f_q, 1'b1);
      end

      // async reset between edges clears f_q before the next edge
      en = 1'b1;
      s = 2'b01;
      I = 4'b0010;
      tick("pre_async");
      #2;
      rst_n = 1'b0;
      #1;
      check("async_f_q", f_q, 1'b0);
      check("async_f_chg", f_chg, 1'b0);
      check("async_f", f, 1'b1);
      m_q = 1'b0;
      m_chg = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick("post_async");

      // unknown select: both candidates for the low bit of s=x1 are zero
      I = 4'b0101;
      s = 2'bx1;
      #1;
      check("x_select_f", f, 1'b0);
      s = 2'b00;
      @(negedge clk);
      tick("after_x");

      // randomized run
      for (int k = 0; k < 300; k++) begin
         I = 4'($urandom);
         s = 2'($urandom);
         en = ($urandom_range(0, 3) != 0);
         tick("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
